// File: rtl/uart_msg_ctrl.sv
// Message sequencer in front of a UART Tx/Rx pair: sends an NBYTES message over the
// Tx_WR/Tx_BUSY handshake while collecting NBYTES received bytes into rx_msg.
module uart_msg_ctrl #(
    parameter int NBYTES      = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int RX_TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [8*NBYTES-1:0] tx_msg,
    output logic [7:0]          Tx_DATA,
    output logic                Tx_WR,
    input  logic                Tx_BUSY,
    input  logic [7:0]          Rx_DATA,
    input  logic                Rx_VALID,
    input  logic                Rx_FERROR,
    input  logic                Rx_PERROR,
    output logic [8*NBYTES-1:0] rx_msg,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    localparam int SW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW = $clog2(NBYTES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(RX_TIMEOUT + 1);
    localparam logic [SW-1:0] LAST_TX  = SW'(NBYTES - 1);
    localparam logic [IW-1:0] RX_FULL  = IW'(NBYTES);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RX_LAST  = RW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_RX   = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t                 state_r;
    logic [NBYTES-1:0][7:0] shadow_r;
    logic [NBYTES-1:0][7:0] rx_buf_r;
    logic [SW-1:0]          tx_idx_r;
    logic [IW-1:0]          rx_idx_r;
    logic [AW-1:0]          ack_cnt_r;
    logic [RW-1:0]          rx_cnt_r;
    logic                   rx_valid_r;

    logic capture_s;
    logic rx_take_s;
    logic rx_bad_s;
    logic rx_store_s;
    logic ack_to_s;
    logic rx_to_s;

    // Rx capture is live from WRITE through WAIT_RX; only a fresh rising edge of Rx_VALID counts.
    assign capture_s  = (state_r == ST_WRITE) || (state_r == ST_WAIT_ACK) ||
                        (state_r == ST_WAIT_DONE) || (state_r == ST_WAIT_RX);
    assign rx_take_s  = capture_s && Rx_VALID && !rx_valid_r && (rx_idx_r < RX_FULL);
    assign rx_bad_s   = rx_take_s && (Rx_FERROR || Rx_PERROR);
    assign rx_store_s = rx_take_s && !(Rx_FERROR || Rx_PERROR);
    assign ack_to_s   = (state_r == ST_WAIT_ACK) && !Tx_BUSY && (ack_cnt_r == ACK_LAST);
    assign rx_to_s    = (state_r == ST_WAIT_RX) && (rx_idx_r != RX_FULL) && !rx_store_s &&
                        (rx_cnt_r == RX_LAST);

    assign rx_msg = rx_buf_r;

    // Sequencer state, byte capture, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shadow_r   <= '0;
            rx_buf_r   <= '0;
            tx_idx_r   <= '0;
            rx_idx_r   <= '0;
            ack_cnt_r  <= '0;
            rx_cnt_r   <= '0;
            rx_valid_r <= 1'b0;
            Tx_DATA    <= 8'h00;
            Tx_WR      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            rx_valid_r <= Rx_VALID;
            Tx_WR      <= 1'b0;
            done       <= 1'b0;
            if (rx_store_s) begin
                rx_buf_r[rx_idx_r[SW-1:0]] <= Rx_DATA;
                rx_idx_r                   <= rx_idx_r + IW'(1);
                rx_cnt_r                   <= '0;
            end
            // Coincident faults resolve as rx error, then ack timeout, then rx timeout.
            if (rx_bad_s || ack_to_s || rx_to_s) begin
                state_r <= ST_ERROR;
                err     <= 1'b1;
                if (rx_bad_s) begin
                    err_code <= 2'b01;
                end else if (ack_to_s) begin
                    err_code <= 2'b10;
                end else begin
                    err_code <= 2'b11;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            shadow_r  <= tx_msg;
                            rx_buf_r  <= '0;
                            err       <= 1'b0;
                            err_code  <= 2'b00;
                            tx_idx_r  <= '0;
                            rx_idx_r  <= '0;
                            ack_cnt_r <= '0;
                            rx_cnt_r  <= '0;
                            busy      <= 1'b1;
                            Tx_DATA   <= tx_msg[7:0];
                            Tx_WR     <= 1'b1;
                            state_r   <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        ack_cnt_r <= '0;
                        state_r   <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (Tx_BUSY) begin
                            state_r <= ST_WAIT_DONE;
                        end else begin
                            ack_cnt_r <= ack_cnt_r + AW'(1);
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (!Tx_BUSY) begin
                            if (tx_idx_r == LAST_TX) begin
                                state_r <= ST_WAIT_RX;
                            end else begin
                                tx_idx_r <= tx_idx_r + SW'(1);
                                Tx_DATA  <= shadow_r[tx_idx_r + SW'(1)];
                                Tx_WR    <= 1'b1;
                                state_r  <= ST_WRITE;
                            end
                        end
                    end
                    ST_WAIT_RX: begin
                        if (rx_idx_r == RX_FULL) begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (!rx_store_s) begin
                            rx_cnt_r <= rx_cnt_r + RW'(1);
                        end
                    end
                    ST_DONE: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    ST_ERROR: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Randomized bench for uart_msg_ctrl: a behavioural UART responder (ack, busy, loopback
// echo, error injection) plus a transaction-level model of the expected outcome.
module tb_uart_msg_ctrl;
    localparam int NB   = 4;
    localparam int ACKT = 16;
    localparam int RXT  = 100;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [31:0]   tx_msg;
    logic [7:0]    Tx_DATA;
    logic          Tx_WR, Tx_BUSY;
    logic [7:0]    Rx_DATA;
    logic          Rx_VALID, Rx_FERROR, Rx_PERROR;
    logic [31:0]   rx_msg;
    logic          busy, done, err;
    logic [1:0]    err_code;

    uart_msg_ctrl #(.NBYTES(NB), .ACK_TIMEOUT(ACKT), .RX_TIMEOUT(RXT)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_msg(tx_msg),
        .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_BUSY(Tx_BUSY),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR),
        .rx_msg(rx_msg), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // responder state
    bit         ack_en, loop_en, extra;
    int         perr_at, ack_wait, busy_left, rx_hold, rx_gap, edge_n, tx_fall;
    logic [7:0] last_byte;
    logic [7:0] rx_q[$];

    // monitor state
    logic [7:0] tx_seen[$];
    int         wr_cyc[$];
    int         done_cnt, done_cyc, err_rise, busy_fall, wr_after_err;
    logic       prev_busy, prev_err, seen_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_ack_delay();
        int r;
        r = $urandom % 4;
        if (r == 0) return 0;
        if (r == 1) return ACKT;
        return $urandom_range(ACKT, 1);
    endfunction

    // One clock: sample outputs after the edge, then advance the UART responder.
    task automatic tick();
        bit raised;
        @(posedge clk);
        #1;
        cyc++;
        raised = 1'b0;
        if (busy) seen_busy = 1'b1;
        if (prev_busy && !busy) busy_fall = cyc;
        if (err && !prev_err) err_rise = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        prev_busy = busy;
        prev_err  = err;
        if (Tx_WR) begin
            tx_seen.push_back(Tx_DATA);
            wr_cyc.push_back(cyc);
            last_byte = Tx_DATA;
            if (err) wr_after_err++;
            if (ack_en) ack_wait = pick_ack_delay();
        end
        if (ack_wait == 0) begin
            Tx_BUSY = 1'b1; busy_left = 2 + $urandom % 3; ack_wait = -1; raised = 1'b1;
        end else if (ack_wait > 0) begin
            ack_wait--;
        end
        if (Tx_BUSY && !raised) begin
            if (busy_left <= 1) begin
                Tx_BUSY = 1'b0;
                tx_fall = cyc;
                if (loop_en) begin
                    rx_q.push_back(last_byte);
                    if (extra && tx_seen.size() == NB) rx_q.push_back(8'($urandom));
                end
            end else begin
                busy_left--;
            end
        end
        if (rx_hold > 0) begin
            rx_hold--;
            if (rx_hold == 0) begin
                Rx_VALID  = 1'b0;
                Rx_PERROR = 1'($urandom % 2);
                Rx_FERROR = 1'($urandom % 2);
                rx_gap    = 1 + $urandom % 2;
            end
        end else if (rx_gap > 0) begin
            rx_gap--;
        end else if (rx_q.size() > 0) begin
            Rx_DATA   = rx_q.pop_front();
            Rx_VALID  = 1'b1;
            Rx_PERROR = 1'b0;
            Rx_FERROR = 1'b0;
            edge_n++;
            if (edge_n == perr_at) begin
                if ($urandom % 2) Rx_PERROR = 1'b1; else Rx_FERROR = 1'b1;
            end
            rx_hold = 1 + $urandom % 3;
        end
    endtask

    function automatic bit responder_idle();
        return !Tx_BUSY && (ack_wait < 0) && (rx_q.size() == 0) && (rx_hold == 0) && !Rx_VALID;
    endfunction

    task automatic clear_responder();
        Tx_BUSY = 1'b0; ack_wait = -1; busy_left = 0; rx_q.delete();
        Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0; rx_hold = 0; rx_gap = 0;
    endtask

    // kind: 0 normal loopback, 1 no Tx ack, 2 rx error on edge perr, 3 receiver silent
    task automatic run_txn(input int kind, input logic [31:0] msg, input int perr,
                           input bit pre, input bit ext, input bit disturb);
        int          n;
        bit          rs_done;
        logic [63:0] exp_rx;
        rs_done = 1'b0;
        ack_en  = (kind != 1);
        loop_en = (kind != 3);
        perr_at = (kind == 2) ? perr : 0;
        extra   = ext;
        tx_seen.delete(); wr_cyc.delete();
        done_cnt = 0; done_cyc = -1; err_rise = -1; busy_fall = -1; wr_after_err = 0;
        edge_n = 0; seen_busy = 1'b0; tx_fall = -1;
        prev_busy = busy; prev_err = err;
        if (pre) begin
            Rx_DATA = 8'($urandom); Rx_VALID = 1'b1; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
            rx_hold = 3 + $urandom % 4;
            tick();
        end
        tx_msg = msg;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_on_start", busy, 1);
        check("wr_on_start", Tx_WR, 1);
        check("err_clr_on_start", err, 0);
        for (int k = 0; k < 3000; k++) begin
            if (disturb && !rs_done && tx_seen.size() == 2) begin
                start = 1'b1; tx_msg = ~msg; rs_done = 1'b1;
            end
            if (disturb && tx_seen.size() == 3) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                start = 1'b0;
                check("rst_mid_outs", {Tx_DATA, Tx_WR, busy, done, err, err_code}, 0);
                check("rst_mid_rx_msg", rx_msg, 0);
                for (int i = 0; i < 3; i++) check("restart_ignored_byte", tx_seen[i], msg[8*i +: 8]);
                clear_responder();
                repeat (6) tick();
                check("no_done_after_rst", done_cnt, 0);
                check("idle_after_rst", busy, 0);
                return;
            end
            tick();
            start = 1'b0;
            if (seen_busy && !busy) break;
        end
        check("txn_finished", (seen_busy && !busy), 1);
        for (int k = 0; k < 300; k++) begin
            if (responder_idle()) break;
            tick();
        end

        case (kind)
            0:       exp_rx = {32'h0, msg};
            2:       exp_rx = {32'h0, msg} & ((64'd1 << (8 * (perr - 1))) - 64'd1);
            default: exp_rx = 64'd0;
        endcase
        n = tx_seen.size();
        if (kind == 1)      check("tx_count_ackto", n, 1);
        else if (kind == 2) check("tx_count_range", (n >= perr) && (n <= NB), 1);
        else                check("tx_count", n, NB);
        for (int i = 0; i < n && i < NB; i++) check("tx_byte", tx_seen[i], msg[8*i +: 8]);
        check("done_cnt", done_cnt, (kind == 0) ? 1 : 0);
        check("err", err, (kind == 0) ? 0 : 1);
        check("err_code", err_code, (kind == 0) ? 0 : (kind == 1) ? 2 : (kind == 2) ? 1 : 3);
        check("rx_msg", rx_msg, exp_rx);
        if (kind == 0) check("busy_drop_after_done", busy_fall, done_cyc + 1);
        else           check("busy_drop_after_err", busy_fall, err_rise + 1);
        if (kind == 1 && n > 0) check("ack_timeout_time", err_rise - wr_cyc[0], ACKT + 1);
        if (kind == 3) check("rx_timeout_time", err_rise - tx_fall, RXT + 1);
        check("wr_after_err", wr_after_err, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tx_msg = 32'h0; Tx_BUSY = 1'b0;
        Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
        ack_en = 1'b1; loop_en = 1'b1; extra = 1'b0; perr_at = 0; ack_wait = -1;
        busy_left = 0; rx_hold = 0; rx_gap = 0; edge_n = 0; last_byte = 8'h00; tx_fall = -1;
        done_cnt = 0; done_cyc = -1; err_rise = -1; busy_fall = -1; wr_after_err = 0;
        prev_busy = 1'b0; prev_err = 1'b0; seen_busy = 1'b0;
        repeat (3) tick();
        check("rst_outs", {Tx_DATA, Tx_WR, busy, done, err, err_code}, 0);
        check("rst_rx_msg", rx_msg, 0);
        reset = 1'b0;
        tick();

        run_txn(0, 32'hA55A_0F3C, 0, 1'b0, 1'b0, 1'b0);
        run_txn(1, $urandom, 0, 1'b0, 1'b0, 1'b0);
        run_txn(2, $urandom, 3, 1'b0, 1'b0, 1'b0);
        run_txn(3, $urandom, 0, 1'b0, 1'b0, 1'b0);
        run_txn(0, $urandom, 0, 1'b0, 1'b0, 1'b1);
        run_txn(0, $urandom, 0, 1'b0, 1'b0, 1'b0);
        run_txn(0, $urandom, 0, 1'b1, 1'b1, 1'b0);
        for (int t = 0; t < 24; t++) begin
            run_txn($urandom % 4, $urandom, 1 + $urandom % NB, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
